// File: rtl/cpu32_pkg.sv
// Shared types and helpers for the 32-bit core writeback path.
// Holds the register-file address/data widths, the queued writeback entry
// type and the circular-pointer increment used by the writeback queue.
package cpu32_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Advance a circular pointer by step slots, wrapping at depth (power of two).
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned step,
                                          input int unsigned depth);
    return (ptr + step) % depth;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// 2-push/2-pop circular buffer of writeback entries with occupancy count.
// Latency: pushed entries are visible in mem_o/count_o after the next edge.
// Backpressure: none internally; the caller must only push into free slots.
module wb_fifo2
  import cpu32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      push_vld_i,
  input  wb_entry_t       push_dat0_i,
  input  wb_entry_t       push_dat1_i,
  input  logic [1:0]      pop_cnt_i,
  output wb_entry_t       mem_o [DEPTH],
  output logic [PW-1:0]   rd_ptr_o,
  output logic [CW-1:0]   count_o
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, wr1;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        npush;

  assign npush = {1'b0, push_vld_i[0]} + {1'b0, push_vld_i[1]};
  assign wr1   = PW'(ptr_inc(32'(wr_q), 32'd1, DEPTH));

  // Next pointers and occupancy from this cycle's push and pop counts.
  always_comb begin
    rd_d  = PW'(ptr_inc(32'(rd_q), 32'(pop_cnt_i), DEPTH));
    wr_d  = PW'(ptr_inc(32'(wr_q), 32'(npush), DEPTH));
    cnt_d = cnt_q + CW'(npush) - CW'(pop_cnt_i);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage: lane 0 takes the write slot, lane 1 the slot after any lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_vld_i[0]) mem_q[wr_q] <= push_dat0_i;
      if (push_vld_i[1]) mem_q[push_vld_i[0] ? wr1 : wr_q] <= push_dat1_i;
    end
  end

  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_q;
  assign count_o  = cnt_q;

endmodule

// File: rtl/wb_queue2.sv
// Writeback collector in front of the 2R/2W register file; optional WB_BYPASS_EN adds fwd_data0/1.
// Latency: result accepted at edge N drives write at cycle N+1 earliest.
// Backpressure: in_ready only while >=2 slots free (registered count); wb_stall freezes draining.
module wb_queue2
  import cpu32_pkg::*;
#(
  parameter int addrsize = 5,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in_valid,
  input  logic [addrsize-1:0] in_addr0,
  input  logic [addrsize-1:0] in_addr1,
  input  logic [DATA_W-1:0]   in_data0,
  input  logic [DATA_W-1:0]   in_data1,
  output logic                in_ready,
  input  logic                wb_stall,
  output logic [addrsize-1:0] wa0,
  output logic [addrsize-1:0] wa1,
  output logic [DATA_W-1:0]   wd0,
  output logic [DATA_W-1:0]   wd1,
  output logic [1:0]          write,
  input  logic [addrsize-1:0] qa0,
  input  logic [addrsize-1:0] qa1,
  output logic [1:0]          pend,
  output logic [CW-1:0]       count
`ifdef WB_BYPASS_EN
  ,
  output logic [DATA_W-1:0]   fwd_data0,
  output logic [DATA_W-1:0]   fwd_data1
`endif
);

  wb_entry_t                  fifo_mem [DEPTH];
  logic [PW-1:0]              rd_ptr;
  logic [1:0]                 acc, pop_cnt;
  wb_entry_t                  head0, head1, push0, push1;
  logic [addrsize-1:0]        wa0_q, wa1_q, wa0_d, wa1_d;
  logic [DATA_W-1:0]          wd0_q, wd1_q, wd0_d, wd1_d;
  logic [1:0]                 write_q, write_d;
  logic [1:0][addrsize-1:0]   qa_v;
  logic [1:0]                 pend_d;
`ifdef WB_BYPASS_EN
  logic [1:0][DATA_W-1:0]     fwd_d;
`endif

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign acc      = in_valid & {2{in_ready}};
  assign push0    = '{addr: ADDR_W'(in_addr0), data: in_data0};
  assign push1    = '{addr: ADDR_W'(in_addr1), data: in_data1};

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_vld_i  (acc),
    .push_dat0_i (push0),
    .push_dat1_i (push1),
    .pop_cnt_i   (pop_cnt),
    .mem_o       (fifo_mem),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count)
  );

  assign head0 = fifo_mem[rd_ptr];
  assign head1 = fifo_mem[PW'(ptr_inc(32'(rd_ptr), 32'd1, DEPTH))];

  // Drain up to two oldest entries unless stalled.
  always_comb begin
    pop_cnt = 2'd0;
    if (!wb_stall) begin
      if (count >= CW'(2))      pop_cnt = 2'd2;
      else if (count == CW'(1)) pop_cnt = 2'd1;
    end
  end

  // Map popped entries onto the write ports; a same-address pair keeps only the younger one.
  always_comb begin
    write_d = 2'b00;
    wa0_d   = '0;
    wd0_d   = '0;
    wa1_d   = '0;
    wd1_d   = '0;
    if (pop_cnt != 2'd0) begin
      write_d = 2'b01;
      wa0_d   = addrsize'(head0.addr);
      wd0_d   = head0.data;
    end
    if (pop_cnt == 2'd2) begin
      wa1_d = addrsize'(head1.addr);
      wd1_d = head1.data;
      if (head0.addr == head1.addr) begin
        write_d = 2'b10;
        wa0_d   = '0;
        wd0_d   = '0;
      end else begin
        write_d = 2'b11;
      end
    end
  end

  // Register-file write port register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 2'b00;
      wa0_q   <= '0;
      wa1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
    end else begin
      write_q <= write_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
    end
  end

  assign qa_v = {qa1, qa0};

  // Pending-write search: output register oldest, then queue oldest to newest, so the last hit is the youngest.
  always_comb begin
    pend_d = 2'b00;
`ifdef WB_BYPASS_EN
    fwd_d = '0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (write_q[0] && (wa0_q == qa_v[k])) begin
        pend_d[k] = 1'b1;
`ifdef WB_BYPASS_EN
        fwd_d[k] = wd0_q;
`endif
      end
      if (write_q[1] && (wa1_q == qa_v[k])) begin
        pend_d[k] = 1'b1;
`ifdef WB_BYPASS_EN
        fwd_d[k] = wd1_q;
`endif
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) &&
            (fifo_mem[PW'(ptr_inc(32'(rd_ptr), i, DEPTH))].addr == ADDR_W'(qa_v[k]))) begin
          pend_d[k] = 1'b1;
`ifdef WB_BYPASS_EN
          fwd_d[k] = fifo_mem[PW'(ptr_inc(32'(rd_ptr), i, DEPTH))].data;
`endif
        end
      end
    end
  end

  assign pend  = pend_d;
  assign write = write_q;
  assign wa0   = wa0_q;
  assign wa1   = wa1_q;
  assign wd0   = wd0_q;
  assign wd1   = wd1_q;
`ifdef WB_BYPASS_EN
  assign fwd_data0 = fwd_d[0];
  assign fwd_data1 = fwd_d[1];
`endif

endmodule

// File: tb/tb_wb_queue2.sv
// Bench for wb_queue2: queue-level reference model checked every cycle, plus literal checkpoints.
module tb_wb_queue2;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [4:0]  in_addr0, in_addr1;
  logic [31:0] in_data0, in_data1;
  logic        in_ready;
  logic        wb_stall;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [1:0]  write;
  logic [4:0]  qa0, qa1;
  logic [1:0]  pend;
  logic [2:0]  count;
`ifdef WB_BYPASS_EN
  logic [31:0] fwd_data0, fwd_data1;
`endif

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  wb_queue2 #(.addrsize(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_addr0(in_addr0), .in_addr1(in_addr1),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_ready(in_ready), .wb_stall(wb_stall),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .write(write),
    .qa0(qa0), .qa1(qa1), .pend(pend), .count(count)
`ifdef WB_BYPASS_EN
    , .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  m_write;
  logic [4:0]  m_wa0, m_wa1;
  logic [31:0] m_wd0, m_wd1;
  int          m_np;
  bit          m_rdy;

  initial begin
    m_write = 2'b00;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_write = 2'b00;
      end else begin
        m_rdy   = (DEPTH - mq.size()) >= 2;
        m_np    = wb_stall ? 0 : (mq.size() > 2 ? 2 : mq.size());
        m_write = 2'b00;
        if (m_np >= 1) begin
          m_wa0 = mq[0].a; m_wd0 = mq[0].d; m_write = 2'b01;
        end
        if (m_np == 2) begin
          m_wa1 = mq[1].a; m_wd1 = mq[1].d;
          m_write = (mq[0].a == mq[1].a) ? 2'b10 : 2'b11;
        end
        repeat (m_np) void'(mq.pop_front());
        if (m_rdy && in_valid[0]) mq.push_back('{a: in_addr0, d: in_data0});
        if (m_rdy && in_valid[1]) mq.push_back('{a: in_addr1, d: in_data1});
      end
    end
  end

  // Youngest pending write to address a: queue newest first, then port 1, then port 0.
  function automatic bit m_find(input logic [4:0] a, output logic [31:0] d);
    d = 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) begin d = mq[i].d; return 1'b1; end
    end
    if (m_write[1] && m_wa1 == a) begin d = m_wd1; return 1'b1; end
    if (m_write[0] && m_wa0 == a) begin d = m_wd0; return 1'b1; end
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] f0, f1;
    bit p0, p1;
    if (chk_on && !rst) begin
      p0 = m_find(qa0, f0);
      p1 = m_find(qa1, f1);
      chk("model_count", count, mq.size());
      chk("model_in_ready", in_ready, (DEPTH - mq.size()) >= 2);
      chk("model_write", write, m_write);
      if (m_write[0]) begin
        chk("model_wa0", wa0, m_wa0);
        chk("model_wd0", wd0, m_wd0);
      end
      if (m_write[1]) begin
        chk("model_wa1", wa1, m_wa1);
        chk("model_wd1", wd1, m_wd1);
      end
      chk("model_pend", pend, {p1, p0});
`ifdef WB_BYPASS_EN
      chk("model_fwd0", fwd_data0, f0);
      chk("model_fwd1", fwd_data1, f1);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    in_valid = v; in_addr0 = a0; in_data0 = d0; in_addr1 = a1; in_data1 = d1;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0; qa0 = 5'd0; qa1 = 5'd0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_write", write, 2'b00);
    chk("rst_count", count, 3'd0);
    chk("rst_pend", pend, 2'b00);
    cyc(); cyc();
    rst = 1'b0;
    chk_on = 1'b1;

    // single push
    qa0 = 5'd5; qa1 = 5'd6;
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    cyc();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("single_q_count", count, 3'd1);
    chk("single_q_pend", pend, 2'b01);
    chk("single_q_write", write, 2'b00);
    cyc();
    chk("single_write", write, 2'b01);
    chk("single_wa0", wa0, 5'd5);
    chk("single_wd0", wd0, 32'hDEADBEEF);
    chk("single_pend_out", pend, 2'b01);
    cyc();
    chk("single_write_drop", write, 2'b00);
    chk("single_pend_drop", pend, 2'b00);

    // dual push, same address
    qa0 = 5'd7;
    drive(2'b11, 5'd7, 32'd1, 5'd7, 32'd2);
    cyc();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("same_count", count, 3'd2);
    cyc();
    chk("same_write", write, 2'b10);
    chk("same_wa1", wa1, 5'd7);
    chk("same_wd1", wd1, 32'd2);
    cyc();

    // fill and backpressure
    wb_stall = 1'b1; qa0 = 5'd3; qa1 = 5'd9;
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2);
    cyc();
    drive(2'b11, 5'd3, 32'hA3, 5'd4, 32'hA4);
    cyc();
    chk("full_count", count, 3'd4);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_pend", pend, 2'b01);
    drive(2'b11, 5'd9, 32'hB9, 5'd10, 32'hBA);
    cyc();
    chk("refused_count", count, 3'd4);
    chk("refused_pend", pend, 2'b01);
    chk("stall_write", write, 2'b00);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    wb_stall = 1'b0;
    cyc();
    chk("drain1_write", write, 2'b11);
    chk("drain1_wa0", wa0, 5'd1);
    chk("drain1_wa1", wa1, 5'd2);
    chk("drain1_wd1", wd1, 32'hA2);
    chk("drain1_count", count, 3'd2);
    chk("drain1_in_ready", in_ready, 1'b1);
    cyc();
    chk("drain2_wa0", wa0, 5'd3);
    chk("drain2_wd1", wd1, 32'hA4);
    chk("drain2_count", count, 3'd0);
    cyc();
    chk("drain_done_write", write, 2'b00);

    // wrap-around: continuous dual push and dual drain
    for (int i = 0; i < 10; i++) begin
      qa0 = 5'(2 * i + 1); qa1 = 5'(2 * i + 2);
      drive(2'b11, 5'(2 * i + 1), 32'h1000 + 32'(i), 5'(2 * i + 2), 32'h2000 + 32'(i));
      cyc();
      chk("wrap_count_le2", count <= 3'd2, 1'b1);
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    cyc();
    chk("wrap_last_wa0", wa0, 5'd19);
    chk("wrap_last_wd1", wd1, 32'h2009);
    cyc();
    chk("wrap_empty", count, 3'd0);

    // youngest-write forwarding
    wb_stall = 1'b1; qa0 = 5'd3; qa1 = 5'd4;
    drive(2'b01, 5'd3, 32'h11, 5'd0, 32'h0);
    cyc();
    drive(2'b01, 5'd3, 32'h22, 5'd0, 32'h0);
    cyc();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("byp_pend", pend, 2'b01);
`ifdef WB_BYPASS_EN
    chk("byp_fwd0_queue", fwd_data0, 32'h22);
    chk("byp_fwd1_zero", fwd_data1, 32'h0);
`endif
    wb_stall = 1'b0;
    cyc();
    chk("byp_write", write, 2'b10);
    chk("byp_wd1", wd1, 32'h22);
`ifdef WB_BYPASS_EN
    chk("byp_fwd0_outreg", fwd_data0, 32'h22);
`endif
    cyc();

    // reset mid-drain
    wb_stall = 1'b1; qa0 = 5'd14; qa1 = 5'd12;
    drive(2'b11, 5'd12, 32'hC1, 5'd13, 32'hC2);
    cyc();
    drive(2'b01, 5'd14, 32'hC3, 5'd0, 32'h0);
    cyc();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("pre_rst_count", count, 3'd3);
    wb_stall = 1'b0;
    cyc();
    chk("pre_rst_write", write, 2'b11);
    chk("pre_rst_count1", count, 3'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_write", write, 2'b00);
    chk("mid_rst_count", count, 3'd0);
    chk("mid_rst_pend", pend, 2'b00);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_write", write, 2'b00);
    chk("post_rst_count", count, 3'd0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
